// File: rtl/dma_tile_scheduler.sv
// Splits one 2-D tile descriptor into single-burst DMA commands that never
// cross a BOUNDARY_BYTES line on either side; one command in flight at a time.
module dma_tile_scheduler #(
    parameter int unsigned BEAT_BYTES      = 4,
    parameter int unsigned MAX_BURST_BYTES = 1024,
    parameter int unsigned BOUNDARY_BYTES  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_src_base,
    input  logic [31:0] desc_dst_base,
    input  logic [15:0] desc_rows,
    input  logic [31:0] desc_row_bytes,
    input  logic [31:0] desc_src_stride,
    input  logic [31:0] desc_dst_stride,
    output logic        dma_start,
    output logic [31:0] dma_src_addr,
    output logic [31:0] dma_dst_addr,
    output logic [31:0] dma_size,
    input  logic        dma_done,
    output logic        busy,
    output logic        tile_done,
    output logic        desc_error,
    output logic [15:0] cmd_count
);

    localparam logic [31:0] BEAT  = 32'(BEAT_BYTES);
    localparam logic [31:0] MAXB  = 32'(MAX_BURST_BYTES);
    localparam logic [31:0] BOUND = 32'(BOUNDARY_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CALC,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0] src_base_q, dst_base_q, row_bytes_q, src_stride_q, dst_stride_q;
    logic [15:0] rows_q, row_idx;
    logic [31:0] cur_src, cur_dst, remaining, row_src, row_dst, chunk_q;

    logic        accept, desc_bad, last_chunk, row_last;
    logic [31:0] src_room, dst_room, chunk_calc;

    assign accept     = (state == S_IDLE) && desc_valid && desc_ready;
    assign desc_bad   = (rows_q == 16'd0) || (row_bytes_q == 32'd0) ||
                        ((src_base_q   % BEAT) != 32'd0) ||
                        ((dst_base_q   % BEAT) != 32'd0) ||
                        ((row_bytes_q  % BEAT) != 32'd0) ||
                        ((src_stride_q % BEAT) != 32'd0) ||
                        ((dst_stride_q % BEAT) != 32'd0);
    assign last_chunk = (remaining == chunk_q);
    assign row_last   = (row_idx == rows_q - 16'd1);

    // Room left before the next boundary line, on each side independently.
    assign src_room = BOUND - (cur_src & (BOUND - 32'd1));
    assign dst_room = BOUND - (cur_dst & (BOUND - 32'd1));

    always_comb begin
        chunk_calc = remaining;
        if (chunk_calc > MAXB)     chunk_calc = MAXB;
        if (chunk_calc > src_room) chunk_calc = src_room;
        if (chunk_calc > dst_room) chunk_calc = dst_room;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CHECK;
            S_CHECK: state_nxt = desc_bad ? S_IDLE : S_CALC;
            S_CALC:  state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (dma_done) state_nxt = (last_chunk && row_last) ? S_DONE : S_CALC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the current/next state, so
    // desc_ready returns one cycle after the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_ready <= 1'b1;
            busy       <= 1'b0;
            dma_start  <= 1'b0;
            tile_done  <= 1'b0;
            desc_error <= 1'b0;
        end else begin
            desc_ready <= (state == S_IDLE) && (state_nxt == S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            dma_start  <= (state == S_ISSUE);
            tile_done  <= (state == S_DONE);
            desc_error <= (state == S_CHECK) && desc_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_base_q   <= '0;
            dst_base_q   <= '0;
            rows_q       <= '0;
            row_bytes_q  <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            row_idx      <= '0;
            cur_src      <= '0;
            cur_dst      <= '0;
            remaining    <= '0;
            row_src      <= '0;
            row_dst      <= '0;
            chunk_q      <= '0;
            dma_src_addr <= '0;
            dma_dst_addr <= '0;
            dma_size     <= '0;
            cmd_count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        src_base_q   <= desc_src_base;
                        dst_base_q   <= desc_dst_base;
                        rows_q       <= desc_rows;
                        row_bytes_q  <= desc_row_bytes;
                        src_stride_q <= desc_src_stride;
                        dst_stride_q <= desc_dst_stride;
                        cmd_count    <= '0;
                    end
                end
                S_CHECK: begin
                    if (!desc_bad) begin
                        row_idx   <= '0;
                        cur_src   <= src_base_q;
                        cur_dst   <= dst_base_q;
                        row_src   <= src_base_q;
                        row_dst   <= dst_base_q;
                        remaining <= row_bytes_q;
                    end
                end
                S_CALC: chunk_q <= chunk_calc;
                S_ISSUE: begin
                    dma_src_addr <= cur_src;
                    dma_dst_addr <= cur_dst;
                    dma_size     <= chunk_q;
                    if (cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
                end
                S_WAIT: begin
                    if (dma_done) begin
                        if (last_chunk && !row_last) begin
                            row_idx   <= row_idx + 16'd1;
                            row_src   <= row_src + src_stride_q;
                            row_dst   <= row_dst + dst_stride_q;
                            cur_src   <= row_src + src_stride_q;
                            cur_dst   <= row_dst + dst_stride_q;
                            remaining <= row_bytes_q;
                        end else begin
                            cur_src   <= cur_src + chunk_q;
                            cur_dst   <= cur_dst + chunk_q;
                            remaining <= remaining - chunk_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_tile_scheduler.sv
// Self-checking bench for dma_tile_scheduler: fixed vectors, timing sequences
// and randomized tiles compared against a row/chunk reference model.
module tb_dma_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_src_base = '0;
    logic [31:0] desc_dst_base = '0;
    logic [15:0] desc_rows = '0;
    logic [31:0] desc_row_bytes = '0;
    logic [31:0] desc_src_stride = '0;
    logic [31:0] desc_dst_stride = '0;
    logic        dma_start;
    logic [31:0] dma_src_addr, dma_dst_addr, dma_size;
    logic        dma_done;
    logic        busy, tile_done, desc_error;
    logic [15:0] cmd_count;

    logic resp_done = 1'b0;
    logic man_done  = 1'b0;
    assign dma_done = resp_done | man_done;

    dma_tile_scheduler #(
        .BEAT_BYTES(4),
        .MAX_BURST_BYTES(1024),
        .BOUNDARY_BYTES(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src_base(desc_src_base), .desc_dst_base(desc_dst_base),
        .desc_rows(desc_rows), .desc_row_bytes(desc_row_bytes),
        .desc_src_stride(desc_src_stride), .desc_dst_stride(desc_dst_stride),
        .dma_start(dma_start), .dma_src_addr(dma_src_addr),
        .dma_dst_addr(dma_dst_addr), .dma_size(dma_size),
        .dma_done(dma_done), .busy(busy), .tile_done(tile_done),
        .desc_error(desc_error), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] src, dst, size;
    } cmd_t;

    typedef struct {
        logic [15:0] rows;
        logic [31:0] row_bytes, src, dst, sstride, dstride;
    } desc_t;

    typedef struct {
        desc_t       d;
        bit          err;
        int unsigned ncmd;
        logic [31:0] src0, dst0, size0;
    } vec_t;

    cmd_t got_q[$];
    cmd_t exp_q[$];
    bit   auto_dma = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Auto DMA engine: records each command, checks it stays stable, then
    // answers with one dma_done pulse after a random latency.
    initial forever begin
        @(negedge clk);
        if (auto_dma && rst_n && dma_start) begin
            cmd_t        c;
            int unsigned lat;
            c.src  = dma_src_addr;
            c.dst  = dma_dst_addr;
            c.size = dma_size;
            got_q.push_back(c);
            lat = $urandom_range(0, 3);
            for (int unsigned i = 0; i < lat; i++) begin
                @(negedge clk);
                chk("start_one_cycle", dma_start, 0);
                chk("src_stable", dma_src_addr, c.src);
                chk("dst_stable", dma_dst_addr, c.dst);
                chk("size_stable", dma_size, c.size);
            end
            resp_done = 1'b1;
            @(negedge clk);
            resp_done = 1'b0;
        end
    end

    // Reference: walk rows, cut each row at burst size and at 4 KB lines.
    task automatic model(input desc_t d, output bit err);
        exp_q.delete();
        err = (d.rows == 0) || (d.row_bytes == 0) || (d.src % 4 != 0) || (d.dst % 4 != 0) ||
              (d.row_bytes % 4 != 0) || (d.sstride % 4 != 0) || (d.dstride % 4 != 0);
        if (!err) begin
            for (int unsigned r = 0; r < d.rows; r++) begin
                logic [31:0] s, t, rem, c;
                cmd_t        e;
                s   = d.src + d.sstride * 32'(r);
                t   = d.dst + d.dstride * 32'(r);
                rem = d.row_bytes;
                while (rem != 0) begin
                    c = rem;
                    if (c > 32'd1024) c = 32'd1024;
                    if (c > 32'd4096 - (s % 32'd4096)) c = 32'd4096 - (s % 32'd4096);
                    if (c > 32'd4096 - (t % 32'd4096)) c = 32'd4096 - (t % 32'd4096);
                    e.src = s; e.dst = t; e.size = c;
                    exp_q.push_back(e);
                    s = s + c; t = t + c; rem = rem - c;
                end
            end
        end
    endtask

    task automatic drive_desc(input desc_t d);
        desc_rows       = d.rows;
        desc_row_bytes  = d.row_bytes;
        desc_src_base   = d.src;
        desc_dst_base   = d.dst;
        desc_src_stride = d.sstride;
        desc_dst_stride = d.dstride;
        desc_valid      = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        for (int n = 0; n < 50 && !desc_ready; n++) @(negedge clk);
        chk({name, "_ready_timeout"}, desc_ready, 1);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_desc_ready"}, desc_ready, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_dma_start"}, dma_start, 0);
        chk({name, "_tile_done"}, tile_done, 0);
        chk({name, "_desc_error"}, desc_error, 0);
        chk({name, "_src"}, dma_src_addr, 0);
        chk({name, "_dst"}, dma_dst_addr, 0);
        chk({name, "_size"}, dma_size, 0);
        chk({name, "_cmd_count"}, cmd_count, 0);
    endtask

    // Full tile with the auto DMA engine; commands compared to the model.
    task automatic run_desc(input string name, input desc_t d);
        bit exp_err, saw_err, saw_done;
        int n;
        model(d, exp_err);
        got_q.delete();
        auto_dma = 1'b1;
        wait_ready(name);
        drive_desc(d);
        @(negedge clk);
        desc_valid = 1'b0;
        chk({name, "_ready_drop"}, desc_ready, 0);
        chk({name, "_busy_rise"}, busy, 1);
        saw_err = 0; saw_done = 0; n = 0;
        while (!saw_err && !saw_done && n < 5000) begin
            @(negedge clk);
            n++;
            if (desc_error) saw_err = 1;
            if (tile_done) saw_done = 1;
        end
        chk({name, "_error"}, saw_err, exp_err);
        chk({name, "_tile_done"}, saw_done, !exp_err);
        chk({name, "_ncmds"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk({name, "_cmd_src"}, got_q[i].src, exp_q[i].src);
            chk({name, "_cmd_dst"}, got_q[i].dst, exp_q[i].dst);
            chk({name, "_cmd_size"}, got_q[i].size, exp_q[i].size);
        end
        chk({name, "_cmd_count"}, cmd_count, exp_q.size());
    endtask

    // Single-chunk tile with exact cycle positions; k counts negedges after accept.
    task automatic timing_single(input string name);
        desc_t d;
        d = '{rows: 16'd1, row_bytes: 32'd1024, src: 32'h1000, dst: 32'h2000,
              sstride: 32'd0, dstride: 32'd0};
        auto_dma = 1'b0;
        wait_ready(name);
        drive_desc(d);
        @(negedge clk);
        desc_valid = 1'b0;
        chk({name, "_k1_ready"}, desc_ready, 0);
        chk({name, "_k1_busy"}, busy, 1);
        chk({name, "_k1_count"}, cmd_count, 0);
        chk({name, "_k1_start"}, dma_start, 0);
        @(negedge clk);
        chk({name, "_k2_start"}, dma_start, 0);
        @(negedge clk);
        chk({name, "_k3_start"}, dma_start, 0);
        @(negedge clk);
        chk({name, "_k4_start"}, dma_start, 1);
        chk({name, "_k4_src"}, dma_src_addr, 32'h1000);
        chk({name, "_k4_dst"}, dma_dst_addr, 32'h2000);
        chk({name, "_k4_size"}, dma_size, 32'd1024);
        chk({name, "_k4_count"}, cmd_count, 1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        chk({name, "_k5_tile_done"}, tile_done, 0);
        chk({name, "_k5_start"}, dma_start, 0);
        chk({name, "_k5_busy"}, busy, 1);
        @(negedge clk);
        chk({name, "_k6_tile_done"}, tile_done, 1);
        chk({name, "_k6_busy"}, busy, 0);
        chk({name, "_k6_ready"}, desc_ready, 0);
        @(negedge clk);
        chk({name, "_k7_ready"}, desc_ready, 1);
        chk({name, "_k7_tile_done"}, tile_done, 0);
        chk({name, "_k7_count"}, cmd_count, 1);
    endtask

    task automatic timing_reject(input string name, input desc_t d);
        auto_dma = 1'b0;
        wait_ready(name);
        drive_desc(d);
        @(negedge clk);
        desc_valid = 1'b0;
        chk({name, "_k1_err"}, desc_error, 0);
        chk({name, "_k1_busy"}, busy, 1);
        @(negedge clk);
        chk({name, "_k2_err"}, desc_error, 1);
        chk({name, "_k2_busy"}, busy, 0);
        chk({name, "_k2_ready"}, desc_ready, 0);
        @(negedge clk);
        chk({name, "_k3_ready"}, desc_ready, 1);
        chk({name, "_k3_err"}, desc_error, 0);
        chk({name, "_k3_start"}, dma_start, 0);
        chk({name, "_k3_count"}, cmd_count, 0);
    endtask

    vec_t tbl[8];

    initial begin
        desc_t d;
        int    n;

        tbl[0] = '{d: '{16'd1, 32'd1024, 32'h1000, 32'h2000, 32'd0, 32'd0},
                   err: 0, ncmd: 1, src0: 32'h1000, dst0: 32'h2000, size0: 32'd1024};
        tbl[1] = '{d: '{16'd1, 32'd2048, 32'h0F00, 32'h8000, 32'd0, 32'd0},
                   err: 0, ncmd: 3, src0: 32'h0F00, dst0: 32'h8000, size0: 32'd256};
        tbl[2] = '{d: '{16'd3, 32'd64, 32'h0, 32'h10000, 32'd256, 32'd64},
                   err: 0, ncmd: 3, src0: 32'h0, dst0: 32'h10000, size0: 32'd64};
        tbl[3] = '{d: '{16'd1, 32'd6, 32'h0, 32'h0, 32'd0, 32'd0},
                   err: 1, ncmd: 0, src0: 0, dst0: 0, size0: 0};
        tbl[4] = '{d: '{16'd0, 32'd64, 32'h0, 32'h0, 32'd0, 32'd0},
                   err: 1, ncmd: 0, src0: 0, dst0: 0, size0: 0};
        tbl[5] = '{d: '{16'd2, 32'd64, 32'h0, 32'h0, 32'd256, 32'd66},
                   err: 1, ncmd: 0, src0: 0, dst0: 0, size0: 0};
        tbl[6] = '{d: '{16'd1, 32'd16, 32'hFFFF_FFF8, 32'h100, 32'd0, 32'd0},
                   err: 0, ncmd: 2, src0: 32'hFFFF_FFF8, dst0: 32'h100, size0: 32'd8};
        tbl[7] = '{d: '{16'd1, 32'd4096, 32'h0, 32'h3FFC, 32'd0, 32'd0},
                   err: 0, ncmd: 5, src0: 32'h0, dst0: 32'h3FFC, size0: 32'd4};

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        timing_single("single");
        d = '{16'd1, 32'd6, 32'h0, 32'h0, 32'd0, 32'd0};
        timing_reject("rej_bytes", d);
        d = '{16'd0, 32'd64, 32'h0, 32'h0, 32'd0, 32'd0};
        timing_reject("rej_rows", d);

        for (int i = 0; i < 8; i++) begin
            run_desc($sformatf("vec%0d", i), tbl[i].d);
            chk($sformatf("vec%0d_model_n", i), exp_q.size(), tbl[i].ncmd);
            if (got_q.size() > 0 && tbl[i].ncmd > 0) begin
                chk($sformatf("vec%0d_first_src", i), got_q[0].src, tbl[i].src0);
                chk($sformatf("vec%0d_first_dst", i), got_q[0].dst, tbl[i].dst0);
                chk($sformatf("vec%0d_first_size", i), got_q[0].size, tbl[i].size0);
            end
        end

        // desc_valid held through WAIT with different fields: no second accept.
        auto_dma = 1'b0;
        wait_ready("hold");
        d = '{16'd1, 32'd64, 32'h40, 32'h80, 32'd0, 32'd0};
        drive_desc(d);
        @(negedge clk);
        desc_rows = 16'd2; desc_src_base = 32'h5000;
        n = 0;
        while (!dma_start && n < 10) begin @(negedge clk); n++; end
        chk("hold_first_start", dma_start, 1);
        repeat (4) begin
            @(negedge clk);
            chk("hold_busy", busy, 1);
            chk("hold_ready", desc_ready, 0);
            chk("hold_no_restart", dma_start, 0);
            chk("hold_src", dma_src_addr, 32'h40);
        end
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        n = 0;
        while (!tile_done && n < 10) begin @(negedge clk); n++; end
        chk("hold_tile_done", tile_done, 1);
        chk("hold_ready_at_done", desc_ready, 0);
        desc_valid = 1'b0;
        @(negedge clk);
        chk("hold_ready_after", desc_ready, 1);
        chk("hold_count", cmd_count, 1);

        // dma_done while idle is ignored.
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_ready", desc_ready, 1);
        chk("idle_done_start", dma_start, 0);
        chk("idle_done_tile", tile_done, 0);
        chk("idle_done_count", cmd_count, 1);

        // Boundary split by hand: done also high in CALC, then reset mid-tile.
        wait_ready("split");
        d = '{16'd1, 32'd2048, 32'h0F00, 32'h8000, 32'd0, 32'd0};
        drive_desc(d);
        @(negedge clk);
        desc_valid = 1'b0;
        n = 0;
        while (!dma_start && n < 10) begin @(negedge clk); n++; end
        chk("split_c0_start", dma_start, 1);
        chk("split_c0_src", dma_src_addr, 32'h0F00);
        chk("split_c0_dst", dma_dst_addr, 32'h8000);
        chk("split_c0_size", dma_size, 32'd256);
        repeat (2) begin
            @(negedge clk);
            chk("split_wait_start", dma_start, 0);
            chk("split_wait_tile", tile_done, 0);
        end
        man_done = 1'b1;
        @(negedge clk);
        chk("split_calc_start", dma_start, 0);
        @(negedge clk);
        man_done = 1'b0;
        chk("split_issue_start", dma_start, 0);
        @(negedge clk);
        chk("split_c1_start", dma_start, 1);
        chk("split_c1_src", dma_src_addr, 32'h1000);
        chk("split_c1_dst", dma_dst_addr, 32'h8100);
        chk("split_c1_size", dma_size, 32'd1024);
        chk("split_c1_count", cmd_count, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset_a");
        @(negedge clk);
        check_reset_vals("midreset_b");
        rst_n = 1'b1;
        @(negedge clk);
        timing_single("post_reset");

        for (int i = 0; i < 40; i++) begin
            d.rows      = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
            d.row_bytes = 32'($urandom_range(1, 800)) * 32'd4;
            d.src       = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1)
                d.src = (d.src & 32'hFFFF_F000) | (32'd4096 - 32'd4 * 32'($urandom_range(1, 64)));
            d.dst       = $urandom & 32'hFFFF_FFFC;
            d.sstride   = 32'($urandom_range(0, 2048)) * 32'd4;
            d.dstride   = 32'($urandom_range(0, 2048)) * 32'd4;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0: d.src       = d.src | 32'd2;
                    1: d.dst       = d.dst | 32'd1;
                    2: d.row_bytes = d.row_bytes | 32'd2;
                    3: d.sstride   = d.sstride | 32'd1;
                    default: d.dstride = d.dstride | 32'd2;
                endcase
            end
            run_desc($sformatf("rand%0d", i), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_tile_scheduler.md
# dma_tile_scheduler

Upstream command generator for the segmentation accelerator's DMA engine. It accepts one 2-D tile descriptor (rows × row_bytes with independent source/destination strides) and breaks it into a sequence of single-transfer DMA commands. Each command is at most one 256-beat burst and never crosses a 4 KB boundary on either side. Commands are issued one at a time: the block waits for the DMA engine's completion pulse before issuing the next.

## Interface
- BEAT_BYTES, 4, bytes per AXI data beat; all addresses, strides and sizes must be multiples of this
- MAX_BURST_BYTES, 1024, largest single command (256 beats × 4 B)
- BOUNDARY_BYTES, 4096, address boundary no command may cross; power of two
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- desc_valid  in  1  descriptor fields valid
- desc_ready  out  1  block idle, can accept a descriptor
- desc_src_base  in  32  byte address of row 0 source
- desc_dst_base  in  32  byte address of row 0 destination
- desc_rows  in  16  row count
- desc_row_bytes  in  32  bytes per row
- desc_src_stride  in  32  byte distance between source row starts
- desc_dst_stride  in  32  byte distance between destination row starts
- dma_start  out  1  one-cycle command strobe to the DMA engine
- dma_src_addr  out  32  command source address, stable from dma_start until dma_done
- dma_dst_addr  out  32  command destination address, same stability rule
- dma_size  out  32  command length in bytes
- dma_done  in  1  one-cycle completion pulse from the DMA engine
- busy  out  1  descriptor in progress
- tile_done  out  1  one-cycle pulse: last command of the tile completed
- desc_error  out  1  one-cycle pulse: descriptor rejected
- cmd_count  out  16  commands issued for the current tile; saturates at 0xFFFF; cleared on accept

## Operation
- **Reset values:** desc_ready=1; busy, dma_start, tile_done, desc_error = 0; dma_src_addr, dma_dst_addr, dma_size, cmd_count = 0. State = IDLE.
- **IDLE**
  - desc_ready=1.
  - On desc_valid&&desc_ready: latch all descriptor fields, clear cmd_count, go to CHECK.
- **CHECK** (desc_ready=0, busy=1). The descriptor is invalid if any of the following hold:
  - rows==0
  - row_bytes==0
  - any of src_base, dst_base, row_bytes, src_stride, dst_stride is not a multiple of BEAT_BYTES

  Invalid: pulse desc_error, return to IDLE, no command issued. Valid: initialise row index=0, cur_src=src_base, cur_dst=dst_base, remaining=row_bytes, row_src=src_base, row_dst=dst_base, go to CALC.
- **CALC:** chunk = min(remaining, MAX_BURST_BYTES, BOUNDARY_BYTES − (cur_src mod BOUNDARY_BYTES), BOUNDARY_BYTES − (cur_dst mod BOUNDARY_BYTES)). Register it, go to ISSUE.
- **ISSUE:** drive dma_start=1 for exactly one cycle with dma_src_addr=cur_src, dma_dst_addr=cur_dst, dma_size=chunk. Increment cmd_count (saturating). Go to WAIT.
- **WAIT:** hold the dma_* address and size outputs. On dma_done:
  - Update cur_src+=chunk, cur_dst+=chunk, remaining−=chunk.
  - remaining now 0 and row==rows−1: go to DONE.
  - remaining now 0, other rows pending: row+=1, row_src+=src_stride, row_dst+=dst_stride, cur_src/cur_dst reload from the new row_src/row_dst, remaining=row_bytes, go to CALC.
  - remaining nonzero: go to CALC.
- **DONE:** pulse tile_done, go to IDLE. busy drops on the same edge.
- **Arithmetic:** all 32-bit unsigned; address addition wraps modulo 2^32 with no error.
- **Boundary conditions**
  - dma_done outside WAIT is ignored.
  - desc_valid while busy is ignored, not queued.
  - The DMA engine must deliver exactly one dma_done pulse per dma_start. A level held high completes each subsequent command on its first WAIT cycle; that is a system integration error, not checked here.
  - rst_n asserted mid-tile forces all reset values immediately. The in-flight DMA command is not tracked or cancelled.

## Timing
- All outputs are registered.
- Descriptor accepted at edge T: CHECK during T+1, CALC T+2, dma_start high in the cycle after edge T+3 (3-cycle accept-to-command latency).
- desc_error is high in the cycle following CHECK.
- dma_done sampled at edge D: next dma_start is high after edge D+2 (CALC, ISSUE).
- After the final dma_done at edge D: tile_done is high after edge D+1 and desc_ready is high after edge D+2.
- Single-row, single-chunk tile: accept to tile_done is 5 cycles plus DMA latency.

## Test plan
- **Single chunk:** rows=1, row_bytes=1024, src=0x1000, dst=0x2000 → one command (0x1000, 0x2000, 1024); tile_done 1 cycle after dma_done; cmd_count=1.
- **Boundary split:** rows=1, row_bytes=2048, src=0x0F00, dst=0x8000 → three commands:
  - (0x0F00, 0x8000, 256)
  - (0x1000, 0x8100, 1024)
  - (0x1400, 0x8500, 768)
- **Strided rows:** rows=3, row_bytes=64, src=0, src_stride=256, dst=0x10000, dst_stride=64 → sources 0x000/0x100/0x200, destinations 0x10000/0x10040/0x10080, size 64 each; cmd_count=3; one tile_done.
- **Rejects:** row_bytes=6 → desc_error pulse, no dma_start, desc_ready=1 two cycles after accept. Repeat with rows=0 → same result.
- **Ignored inputs:** desc_valid held high during WAIT → no second accept; dma_done pulsed during IDLE/CALC → no state change.
- **Reset mid-tile:** rst_n low during WAIT of the second command → all outputs at reset values while low. After release, a new descriptor is accepted and issues its first command 3 cycles later.
